// File: rtl/riot_timer_io_if.sv
// CPU-side register bus of the RIOT block: one strobe per access, registered read data.
interface riot_timer_io_if;
    logic       stb_i;
    logic       we_i;
    logic [6:0] adr_i;
    logic [7:0] dat_i;
    logic [7:0] dat_o;

    modport master (output stb_i, we_i, adr_i, dat_i, input dat_o);
    modport slave  (input stb_i, we_i, adr_i, dat_i, output dat_o);
endinterface

// File: rtl/riot_timer_io.sv
// 6532-style RIOT: up to two I/O ports with direction registers, prescaled
// interval timer with underflow flag, and an edge-detect flag on port 0 MSB.
module riot_timer_io #(
    parameter int NUM_PORTS    = 2,
    parameter int PORT_W       = 8,
    parameter int TIMER_W      = 8,
    parameter int CLK_PER_TICK = 24
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    riot_timer_io_if.slave              bus,
    input  logic [NUM_PORTS*PORT_W-1:0] port_i,
    output logic [NUM_PORTS*PORT_W-1:0] port_o,
    output logic [NUM_PORTS*PORT_W-1:0] port_oe,
    output logic                        irq_o
);
    localparam int TICK_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_TICK - 1);

    logic rd_en;
    logic wr_en;
    logic adr_port;
    logic adr_edge;
    logic adr_timer;

    assign rd_en     = bus.stb_i & ~bus.we_i;
    assign wr_en     = bus.stb_i &  bus.we_i;
    assign adr_port  = (bus.adr_i[6:2] == 5'b00000);
    assign adr_edge  = (bus.adr_i[6:2] == 5'b00001);
    assign adr_timer = (bus.adr_i[6:4] == 3'b001) && bus.adr_i[2];

    // Per-port read views, padded to two entries so the read mux never
    // indexes past the configured port count.
    logic [7:0] pin_rd [2];
    logic [7:0] ddr_rd [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        if (gi < NUM_PORTS) begin : g_used
            logic [PORT_W-1:0] out_q;
            logic [PORT_W-1:0] ddr_q;
            logic [PORT_W-1:0] pin;

            assign pin = port_i[gi*PORT_W +: PORT_W];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    out_q <= '0;
                    ddr_q <= '0;
                end else if (wr_en && adr_port) begin
                    if (bus.adr_i[1:0] == 2'(2*gi)) begin
                        out_q <= bus.dat_i[PORT_W-1:0];
                    end
                    if (bus.adr_i[1:0] == 2'(2*gi+1)) begin
                        ddr_q <= bus.dat_i[PORT_W-1:0];
                    end
                end
            end

            assign pin_rd[gi] = 8'((out_q & ddr_q) | (pin & ~ddr_q));
            assign ddr_rd[gi] = 8'(ddr_q);
            assign port_o [gi*PORT_W +: PORT_W] = out_q;
            assign port_oe[gi*PORT_W +: PORT_W] = ddr_q;
        end else begin : g_unused
            assign pin_rd[gi] = '0;
            assign ddr_rd[gi] = '0;
        end
    end

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [9:0]         presc_q, presc_d;
    logic [1:0]         ival_q, ival_d;
    logic [TIMER_W-1:0] intim_q, intim_d;
    logic               tim_flag_q, tim_flag_d;
    logic               tim_ie_q, tim_ie_d;
    logic               edg_flag_q, edg_flag_d;
    logic               edg_ie_q, edg_ie_d;
    logic               edg_rise_q, edg_rise_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [7:0]         dat_q;
    logic [7:0]         rd_data;
    logic [9:0]         presc_last;
    logic               tick;
    logic               dec;
    logic               underflow;
    logic               edge_hit;
    logic               rd_intim;
    logic               rd_flags;

    // ival_q encodes the interval: 0=1, 1=8, 2=64, 3=1024 ticks per decrement.
    always_comb begin
        presc_last = 10'd0;
        case (ival_q)
            2'd0: presc_last = 10'd0;
            2'd1: presc_last = 10'd7;
            2'd2: presc_last = 10'd63;
            2'd3: presc_last = 10'd1023;
            default: presc_last = 10'd0;
        endcase
    end

    assign tick      = (tick_cnt_q == TICK_LAST);
    assign dec       = tick && (presc_q == presc_last);
    assign underflow = dec && (intim_q == '0);
    assign edge_hit  = edg_rise_q ? (sync2_q & ~prev_q) : (~sync2_q & prev_q);
    assign rd_intim  = rd_en && adr_edge && !bus.adr_i[0];
    assign rd_flags  = rd_en && adr_edge &&  bus.adr_i[0];

    // Read data is taken from pre-update state, so a flag set in the same
    // cycle as its read shows up only on the following read.
    always_comb begin
        rd_data = '0;
        if (adr_port) begin
            rd_data = bus.adr_i[0] ? ddr_rd[bus.adr_i[1]] : pin_rd[bus.adr_i[1]];
        end else if (adr_edge) begin
            rd_data = bus.adr_i[0] ? {tim_flag_q, edg_flag_q, 6'b0} : 8'(intim_q);
        end
    end

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        presc_d    = presc_q;
        intim_d    = intim_q;
        ival_d     = ival_q;
        tim_flag_d = tim_flag_q;
        tim_ie_d   = tim_ie_q;
        edg_ie_d   = edg_ie_q;
        edg_rise_d = edg_rise_q;
        edg_flag_d = edg_flag_q;

        if (tick) begin
            presc_d = (presc_q == presc_last) ? 10'd0 : presc_q + 10'd1;
        end
        if (dec) begin
            intim_d = intim_q - TIMER_W'(1);
        end
        if (underflow) begin
            tim_flag_d = 1'b1;
            ival_d     = 2'd0;
        end else if (rd_intim) begin
            tim_flag_d = 1'b0;
        end

        // A load restarts the whole countdown and overrides any decrement above.
        if (wr_en && adr_timer) begin
            intim_d    = bus.dat_i[TIMER_W-1:0];
            presc_d    = '0;
            tick_cnt_d = '0;
            tim_flag_d = 1'b0;
            ival_d     = bus.adr_i[1:0];
            tim_ie_d   = bus.adr_i[3];
        end

        if (wr_en && adr_edge) begin
            edg_rise_d = bus.adr_i[0];
            edg_ie_d   = bus.adr_i[1];
        end

        if (edge_hit) begin
            edg_flag_d = 1'b1;
        end else if (rd_flags) begin
            edg_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= '0;
            presc_q    <= '0;
            intim_q    <= '0;
            ival_q     <= 2'd3;
            tim_flag_q <= 1'b0;
            tim_ie_q   <= 1'b0;
            edg_flag_q <= 1'b0;
            edg_ie_q   <= 1'b0;
            edg_rise_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            dat_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            presc_q    <= presc_d;
            intim_q    <= intim_d;
            ival_q     <= ival_d;
            tim_flag_q <= tim_flag_d;
            tim_ie_q   <= tim_ie_d;
            edg_flag_q <= edg_flag_d;
            edg_ie_q   <= edg_ie_d;
            edg_rise_q <= edg_rise_d;
            sync1_q    <= port_i[PORT_W-1];
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            if (rd_en) begin
                dat_q <= rd_data;
            end
        end
    end

    assign bus.dat_o = dat_q;
    assign irq_o     = (tim_flag_q & tim_ie_q) | (edg_flag_q & edg_ie_q);

endmodule

// File: doc/riot_timer_io.md
Name: riot_timer_io

Overview:
- Parametrised successor to the Atari 2600 PIA: a 6532-style RIOT block on the same stb/we/adr/dat bus.
- Provides up to two bidirectional I/O ports, each with a data-direction register.
- Provides a prescaled interval timer with an underflow flag, plus an edge-detect flag on the MSB of port 0.
- Drives an interrupt output. Sits beside the CPU bus decoder; the console top maps joystick/switch inputs onto the port pins.

Parameters:
- NUM_PORTS, 2, number of I/O ports (1..2); port 1 reads 0 and drives nothing when NUM_PORTS=1.
- PORT_W, 8, pins per port (1..8); unused upper read bits return 0.
- TIMER_W, 8, width of the INTIM counter and timer load value (1..8).
- CLK_PER_TICK, 24, clk_i cycles per timer base tick (>=1).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- stb_i  in  1  bus strobe, one cycle per access.
- we_i  in  1  1=write, 0=read.
- adr_i  in  7  register address.
- dat_i  in  8  write data.
- dat_o  out  8  registered read data.
- port_i  in  NUM_PORTS*PORT_W  pin inputs; port n occupies bits [n*PORT_W +: PORT_W].
- port_o  out  NUM_PORTS*PORT_W  output register values.
- port_oe  out  NUM_PORTS*PORT_W  DDR values; 1 = output.
- irq_o  out  1  (tim_flag & tim_ie) | (edg_flag & edg_ie).

Behaviour:
- Reset (rst_ni low, async): dat_o=0, port_o=0, port_oe=0, intim=0, interval=1024, prescaler=0, tick_cnt=0, tim_flag=0, edg_flag=0, tim_ie=0, edg_ie=0, edge polarity=falling, sync regs=0.
- Reset mid-operation aborts the countdown immediately; no flag survives.
- Bus decode only when stb_i=1. Reads are registered: dat_o updates on the edge after stb, then holds until the next read. Writes take effect on the same edge.
- Read map:
  - 0x00 port0 data: (port_o & port_oe) | (port_i & ~port_oe).
  - 0x01 DDR0.
  - 0x02 port1 data.
  - 0x03 DDR1.
  - 0x04 / 0x06 INTIM, zero-extended; clears tim_flag.
  - 0x05 / 0x07 flags {tim_flag, edg_flag, 6'b0}; clears edg_flag.
- Write map:
  - 0x00–0x03 port/DDR registers (low PORT_W bits).
  - 0x04–0x07 edge control: adr_i[0]=1 selects rising edge, 0 selects falling; adr_i[1] sets edg_ie.
  - 0x14–0x17 and 0x1C–0x1F timer load: adr_i[1:0] selects interval 1/8/64/1024; adr_i[3] sets tim_ie.
  - Unmapped addresses: reads return 0, writes are ignored.
- Timer load: intim <= dat_i[TIMER_W-1:0]; prescaler <= 0; tick_cnt <= 0; tim_flag <= 0.
- Tick: tick_cnt counts 0..CLK_PER_TICK-1; a tick fires when it wraps.
- On a tick, the prescaler increments. When the prescaler reaches interval-1, intim decrements and the prescaler clears.
- The first decrement lands exactly interval*CLK_PER_TICK clocks after the load edge.
- Underflow: when intim decrements 0 -> all-ones, tim_flag <= 1 and interval <= 1 until the next timer load. Decrementing continues and wraps indefinitely.
- Edge detect:
  - port_i MSB of port 0 passes through a 2-FF synchroniser and is compared with the previous synced value.
  - A selected edge sets edg_flag, whether the pin is configured as input or output.
- Precedence:
  - Timer load beats a same-cycle decrement or underflow.
  - A same-cycle flag set beats the clear-on-read (the flag stays 1), and the read returns the pre-set value.
  - A same-cycle edge beats the clear of edg_flag on reading 0x05.
- irq_o is combinational from registered state; no extra latency.

Test Plan:
- Reset, then read 0x00 with port_i=0xA5 and DDR=0 -> dat_o=0xA5 one cycle after stb. port_o=port_oe=0 throughout.
- Write DDR0=0xF0, port0=0x3C, port_i=0x0F -> read 0x00 returns 0x3F; port_oe=0xF0, port_o=0x3C.
- Write 0x15 with 0x02 (CLK_PER_TICK=24) -> intim=1 at load+192 clocks, 0 at +384, 0xFF at +576 with tim_flag=1.
  - Thereafter it decrements every 24 clocks.
  - A read of 0x04 returns the count and clears tim_flag.
- Write 0x1C with 0x00 -> underflow after 24 clocks sets tim_flag and irq_o=1. A timer write in the underflow cycle leaves the flag 0 and reloads.
- Write 0x07 (rising edge, edg_ie=1), toggle port_i[7] 0->1 -> edg_flag and irq_o rise 2–3 clocks later. Read 0x05 returns 0x40 and clears it; a 1->0 transition does not set the flag.
- Assert rst_ni mid-countdown and mid-read -> all outputs return to reset values asynchronously; after release, the timer stays idle at intim=0 until the first tick sequence.
